// File: rtl/mastermind_pkg.sv
// -----------------------------------------------------------------------------
// mastermind_pkg
//   Shared types and defaults for the Mastermind code sampler and the guess
//   scorer. The game is built around NUM_PEGS_DEF pegs drawn from
//   NUM_COLORS_DEF colours. PEG_W and color_t describe one peg at the default
//   colour count. Blocks that take their own NUM_COLORS parameter derive their
//   own peg width from it.
// -----------------------------------------------------------------------------
package mastermind_pkg;

  localparam int NUM_PEGS_DEF   = 4;
  localparam int NUM_COLORS_DEF = 6;
  localparam int PEG_W          = $clog2(NUM_COLORS_DEF);
  localparam int LFSR_W         = 10;

  typedef logic [PEG_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } sampler_state_e;

endpackage

// File: rtl/mastermind_code_sampler_if.sv
// -----------------------------------------------------------------------------
// mastermind_code_sampler_if
//   Bundle between the LFSR / game FSM side (master) and the code sampler
//   (slave).
//   lfsr_in    master->slave  current LFSR output
//   start      master->slave  one-cycle request for a new secret code
//   busy       slave->master  sampling in progress
//   code       slave->master  peg i in code[i*PEG_W +: PEG_W]
//   code_valid slave->master  code complete and stable
//   code_error slave->master  sampling aborted after too many rejections
// -----------------------------------------------------------------------------
interface mastermind_code_sampler_if #(
  parameter int NUM_PEGS = 4,
  parameter int PEG_W    = 3
);
  logic [9:0]                lfsr_in;
  logic                      start;
  logic                      busy;
  logic [NUM_PEGS*PEG_W-1:0] code;
  logic                      code_valid;
  logic                      code_error;

  modport master (
    output lfsr_in, start,
    input  busy, code, code_valid, code_error
  );

  modport slave (
    input  lfsr_in, start,
    output busy, code, code_valid, code_error
  );
endinterface

// File: rtl/mastermind_code_sampler_color_in_use.sv
// -----------------------------------------------------------------------------
// color_in_use
//   Combinational duplicate check. It flags whether candidate colour cand_i
//   already appears in any of the pegs placed so far, which are pegs
//   0..idx_i-1. Pegs at or above idx_i are not yet placed and are ignored.
//   cand_i  candidate colour
//   pegs_i  all peg slots, slot i = pegs_i[i]
//   idx_i   number of pegs already accepted
//   dup_o   1 if cand_i matches an accepted peg
// -----------------------------------------------------------------------------
module color_in_use #(
  parameter int NUM_PEGS = 4,
  parameter int PW       = 3,
  parameter int IDX_W    = 2
) (
  input  logic [PW-1:0]                cand_i,
  input  logic [NUM_PEGS-1:0][PW-1:0]  pegs_i,
  input  logic [IDX_W-1:0]             idx_i,
  output logic                         dup_o
);

  always_comb begin
    dup_o = 1'b0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if ((IDX_W'(i) < idx_i) && (pegs_i[i] == cand_i)) dup_o = 1'b1;
    end
  end

endmodule

// File: rtl/mastermind_code_sampler.sv
// -----------------------------------------------------------------------------
// mastermind_code_sampler
//   Builds the secret Mastermind code from the LFSR stream. It uses rejection
//   sampling so that every colour is equally likely. While sampling, each
//   cycle takes the low PEG_W bits of the LFSR as a candidate colour. The
//   candidate is accepted when it is a legal colour and, with NO_REPEAT=1,
//   does not already appear in the code. MAX_REJECTS rejections in one code
//   abort the run with code_error. This catches a stuck LFSR.
//   clk    clock
//   Reset  synchronous, active-high reset
//   bus    slave side of mastermind_code_sampler_if:
//          lfsr_in/start in; busy/code/code_valid/code_error out
// -----------------------------------------------------------------------------
module mastermind_code_sampler
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS    = NUM_PEGS_DEF,
  parameter int NUM_COLORS  = NUM_COLORS_DEF,
  parameter int NO_REPEAT   = 0,
  parameter int MAX_REJECTS = 64
) (
  input  logic                       clk,
  input  logic                       Reset,
  mastermind_code_sampler_if.slave   bus
);

  localparam int PW    = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
  localparam int IDX_W = (NUM_PEGS > 1)   ? $clog2(NUM_PEGS)   : 1;
  localparam int REJ_W = $clog2(MAX_REJECTS + 1);

  // Parameter sets that cannot work are stopped at elaboration.
  if (NO_REPEAT != 0 && NUM_COLORS < NUM_PEGS) begin : g_bad_norepeat
    $error("mastermind_code_sampler: NO_REPEAT needs NUM_COLORS >= NUM_PEGS");
  end
  if (NUM_COLORS > 8 || NUM_COLORS < 2) begin : g_bad_colors
    $error("mastermind_code_sampler: NUM_COLORS must be in 2..8");
  end
  if (NUM_PEGS < 2) begin : g_bad_pegs
    $error("mastermind_code_sampler: NUM_PEGS must be at least 2");
  end
  if (MAX_REJECTS < 1) begin : g_bad_rej
    $error("mastermind_code_sampler: MAX_REJECTS must be at least 1");
  end

  sampler_state_e              state_q, state_d;
  logic [NUM_PEGS-1:0][PW-1:0] pegs_q, pegs_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [REJ_W-1:0]            rej_q, rej_d;
  logic                        err_q, err_d;

  logic [PW-1:0] cand;
  logic          in_range;
  logic          dup;
  logic          accept;

  assign cand     = bus.lfsr_in[PW-1:0];
  // The extra bit lets NUM_COLORS == 2**PW compare without overflow.
  assign in_range = ({1'b0, cand} < (PW+1)'(NUM_COLORS));

  color_in_use #(
    .NUM_PEGS (NUM_PEGS),
    .PW       (PW),
    .IDX_W    (IDX_W)
  ) u_color_in_use (
    .cand_i (cand),
    .pegs_i (pegs_q),
    .idx_i  (idx_q),
    .dup_o  (dup)
  );

  assign accept = in_range && ((NO_REPEAT == 0) || !dup);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pegs_q  <= '0;
      idx_q   <= '0;
      rej_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pegs_q  <= pegs_d;
      idx_q   <= idx_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pegs_d  = pegs_q;
    idx_d   = idx_q;
    rej_d   = rej_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SAMPLE;
          pegs_d  = '0;
          idx_d   = '0;
          rej_d   = '0;
          err_d   = 1'b0;
        end
      end
      SAMPLE: begin
        // start is ignored here. A run in progress always completes or aborts.
        if (accept) begin
          pegs_d[idx_q] = cand;
          if (idx_q == IDX_W'(NUM_PEGS - 1)) state_d = DONE;
          else                               idx_d   = idx_q + IDX_W'(1);
        end else begin
          // The counter stops at MAX_REJECTS because the state leaves SAMPLE.
          rej_d = rej_q + REJ_W'(1);
          if (rej_q == REJ_W'(MAX_REJECTS - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == SAMPLE);
  assign bus.code       = pegs_q;
  assign bus.code_valid = (state_q == DONE) && !err_q;
  assign bus.code_error = err_q;

endmodule

// File: tb/tb_mastermind_code_sampler.sv
module tb_mastermind_code_sampler;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  mastermind_code_sampler_if #(.NUM_PEGS(4), .PEG_W(3)) b1 ();
  mastermind_code_sampler_if #(.NUM_PEGS(4), .PEG_W(3)) b2 ();

  mastermind_code_sampler u_dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (b1.slave)
  );

  mastermind_code_sampler #(.NO_REPEAT(1)) u_dut_nr (
    .clk   (clk),
    .Reset (Reset),
    .bus   (b2.slave)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // The model works from the game rules: a list of pegs drawn so far,
  // a rejection tally, and three status flags. Index 0 is the default DUT.
  // Index 1 is the NO_REPEAT DUT.
  bit mbusy[2], mval[2], merr[2];
  int mp[2][4];
  int mn[2], mrej[2];

  task automatic model_step(int d, bit rst, bit st, logic [9:0] l, bit nr);
    int  c;
    bit  ok;
    if (rst) begin
      mbusy[d] = 0; mval[d] = 0; merr[d] = 0; mn[d] = 0; mrej[d] = 0;
      for (int i = 0; i < 4; i++) mp[d][i] = 0;
    end else if (mbusy[d]) begin
      c  = int'(l) % 8;
      ok = (c < 6);
      if (nr) for (int i = 0; i < mn[d]; i++) if (mp[d][i] == c) ok = 0;
      if (ok) begin
        mp[d][mn[d]] = c;
        mn[d]++;
        if (mn[d] == 4) begin mbusy[d] = 0; mval[d] = 1; end
      end else begin
        mrej[d]++;
        if (mrej[d] == 64) begin mbusy[d] = 0; merr[d] = 1; end
      end
    end else if (st) begin
      mbusy[d] = 1; mval[d] = 0; merr[d] = 0; mn[d] = 0; mrej[d] = 0;
      for (int i = 0; i < 4; i++) mp[d][i] = 0;
    end
  endtask

  function automatic logic [11:0] mcode(int d);
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) c = c | (12'(mp[d][i]) << (3 * i));
    return c;
  endfunction

  always @(posedge clk) begin
    model_step(0, Reset, b1.start, b1.lfsr_in, 1'b0);
    model_step(1, Reset, b2.start, b2.lfsr_in, 1'b1);
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m0_busy",  32'(b1.busy),       32'(mbusy[0]));
      chk("m0_valid", 32'(b1.code_valid), 32'(mval[0]));
      chk("m0_err",   32'(b1.code_error), 32'(merr[0]));
      chk("m0_code",  32'(b1.code),       32'(mcode(0)));
      chk("m1_busy",  32'(b2.busy),       32'(mbusy[1]));
      chk("m1_valid", 32'(b2.code_valid), 32'(mval[1]));
      chk("m1_err",   32'(b2.code_error), 32'(merr[1]));
      chk("m1_code",  32'(b2.code),       32'(mcode(1)));
    end
  end

  task automatic step(bit s1, logic [9:0] l1, bit s2, logic [9:0] l2);
    b1.start = s1; b1.lfsr_in = l1;
    b2.start = s2; b2.lfsr_in = l2;
    @(negedge clk);
  endtask

  logic [9:0] seq2 [5] = '{10'h005, 10'h007, 10'h002, 10'h000, 10'h003};
  logic [9:0] seq3 [6] = '{10'h001, 10'h001, 10'h004, 10'h004, 10'h002, 10'h005};

  initial begin
    b1.start = 0; b1.lfsr_in = '0; b2.start = 0; b2.lfsr_in = '0;

    // 1: reset with start held high
    Reset = 1;
    for (int i = 0; i < 3; i++) step(1, 10'h0, 1, 10'h0);
    Reset = 0;
    cmp_en = 1;
    chk("rst_busy",  32'(b1.busy), 0);
    chk("rst_valid", 32'(b1.code_valid), 0);
    chk("rst_err",   32'(b1.code_error), 0);
    chk("rst_code",  32'(b1.code), 32'h000);
    step(0, 10'h0, 0, 10'h0);

    // 2: one rejection, start re-pulsed mid-run
    step(1, 10'h0, 0, 10'h0);
    chk("t2_busy", 32'(b1.busy), 1);
    for (int i = 0; i < 5; i++) begin
      step(i == 1, seq2[i], 0, 10'h0);
      if (i == 3) chk("t2_notyet", 32'(b1.code_valid), 0);
    end
    chk("t2_valid", 32'(b1.code_valid), 1);
    chk("t2_busy0", 32'(b1.busy), 0);
    chk("t2_code",  32'(b1.code), 32'h615);

    // 3: NO_REPEAT rejects duplicates
    step(0, 10'h0, 1, 10'h0);
    for (int i = 0; i < 6; i++) begin
      step(0, 10'h0, 0, seq3[i]);
      if (i == 4) chk("t3_notyet", 32'(b2.code_valid), 0);
    end
    chk("t3_valid", 32'(b2.code_valid), 1);
    chk("t3_code",  32'(b2.code), 32'hAA1);
    chk("t3_hold",  32'(b1.code), 32'h615);

    // 6 + 4: restart from DONE, then a stuck LFSR aborts after 64 rejections
    step(1, 10'h3FF, 0, 10'h0);
    chk("t6_valid_drop", 32'(b1.code_valid), 0);
    chk("t6_busy", 32'(b1.busy), 1);
    for (int i = 0; i < 63; i++) step(0, 10'h3FF, 0, 10'h0);
    chk("t4_err_pre",  32'(b1.code_error), 0);
    chk("t4_busy_pre", 32'(b1.busy), 1);
    step(0, 10'h3FF, 0, 10'h0);
    chk("t4_err",   32'(b1.code_error), 1);
    chk("t4_busy",  32'(b1.busy), 0);
    chk("t4_valid", 32'(b1.code_valid), 0);
    step(0, 10'h3FF, 0, 10'h0);
    chk("t4_hold", 32'(b1.code_error), 1);
    step(1, 10'h0, 0, 10'h0);
    chk("t4_clear", 32'(b1.code_error), 0);

    // 5: reset mid-run, then a fresh code
    step(0, 10'h001, 0, 10'h0);
    step(0, 10'h002, 0, 10'h0);
    chk("t5_partial", 32'(b1.code), 32'h011);
    Reset = 1;
    step(1, 10'h001, 1, 10'h0);
    Reset = 0;
    chk("t5_busy", 32'(b1.busy), 0);
    chk("t5_code", 32'(b1.code), 0);
    step(1, 10'h0, 0, 10'h0);
    for (int i = 0; i < 4; i++) step(0, 10'(i), 0, 10'h0);
    chk("t5_valid", 32'(b1.code_valid), 1);
    chk("t5_code2", 32'(b1.code), 32'h688);
    step(0, 10'h0, 0, 10'h0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
